kevin_scan_ctrl: RTL and testbench
==================================

Name: kevin_scan_ctrl

Overview:
Sequencing controller that sweeps a programmable range of 4-bit codes through the Kevin-number detector. It collects per-run results: hit count, 16-bit hit bitmap, and first matching code. It sits between a host/test harness (start/abort handshake) and one combinational detector instance. It turns the stateless detector into a scheduled, observable scan engine.

Parameters:
DWELL, 1, cycles each code is held on the detector before it is evaluated (legal range 1..15).
CODE_W, 4, code width; fixed at 4 and not to be overridden.

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a scan; sampled only in IDLE
abort  in  1  terminate an in-progress scan; sampled only in SCAN
lo  in  4  first code of the range; captured when start is accepted
hi  in  4  last code of the range; captured when start is accepted
busy  out  1  high while in SCAN
done  out  1  one-cycle pulse when a scan completes normally
code  out  4  code currently driven to the detector
hit_cnt  out  5  number of matching codes in the run (0..16)
hit_map  out  16  bit k set if code k matched in the run
first_hit  out  4  first matching code in scan order
first_valid  out  1  first_hit is meaningful
aborted  out  1  last run was terminated by abort

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs are 0, state is IDLE, dwell counter is 0. A reset mid-scan discards the run immediately; no done pulse is produced.
- States:
  - IDLE: start=1 captures lo and hi, sets code=lo, clears hit_cnt/hit_map/first_hit/first_valid/aborted, and moves to SCAN.
  - SCAN: busy=1. The dwell counter counts DWELL cycles per code. Evaluation happens in the last dwell cycle of each code.
  - DONE: done=1, busy=0 for exactly one cycle, then return to IDLE.
- Evaluation at a code's last dwell cycle, when the detector matches:
  - hit_cnt is incremented.
  - hit_map[code] is set.
  - If first_valid=0, first_hit=code and first_valid=1.
- Advance: after evaluation, if code==hi go to DONE; otherwise code=code+1 mod 16 and the dwell counter resets.
- Range and wrap:
  - Number of codes N = ((hi-lo) mod 16)+1.
  - lo==hi scans one code. hi<lo wraps through 15 to 0.
  - lo=0, hi=15 scans all 16 codes, so hit_cnt needs 5 bits.
- Timing: with start sampled at edge E0, SCAN occupies N*DWELL cycles and done is high in the following cycle. The DWELL=1 full scan therefore pulses done in the 17th cycle after E0.
- Abort in SCAN:
  - Go to IDLE and set aborted=1.
  - The evaluation scheduled for that cycle is discarded; earlier results are held.
  - No done pulse is produced.
- start outside IDLE is ignored. abort outside SCAN is ignored.
- start and abort both high in IDLE: start is accepted and abort is ignored.
- Results (hit_cnt, hit_map, first_*, aborted) hold until the next accepted start or reset. code holds its last value in IDLE.
- The detector is purely combinational on code. Results are registered on the evaluation edge.

Decomposition:
- Package kevin_pkg contains:
  - state enum {IDLE, SCAN, DONE}
  - CODE_W=4
  - KEVIN_SET=16'h56E2 (codes 1,5,6,7,9,10,12,14), used by the bench reference model
- Sub-module kevin_match (in[3:0] -> out), the combinational detector, instantiated once on code.

Test Plan:
- DWELL=1, lo=0, hi=15, start pulse -> hit_cnt=8, hit_map=16'h56E2, first_hit=1, first_valid=1, busy high for 16 cycles, done in cycle 17.
- Wrap scan lo=14, hi=1 -> codes 14,15,0,1 scanned in order; hit_cnt=2, hit_map=16'h4002, first_hit=14.
- Single code lo=hi=8 -> busy for 1 cycle, hit_cnt=0, hit_map=0, first_valid=0, done pulses.
- lo=0, hi=15, abort asserted in the 4th SCAN cycle (code=3) -> hit_cnt=1, hit_map=16'h0002, aborted=1, no done, state IDLE next cycle.
- DWELL=3, lo=5, hi=6 -> code=5 for 3 cycles then 6 for 3 cycles, hit_cnt=2, hit_map=16'h0060, done at cycle 7.
- rst asserted mid-scan, and start held during SCAN -> rst zeroes all outputs next cycle; start during SCAN does not restart or alter results.

Source files
------------

// File: rtl/kevin_pkg.sv
// Shared types and constants for the Kevin-number scan controller.
package kevin_pkg;

  // Width of the codes fed to the detector. Fixed at 4; the rest of the
  // design relies on it (16-entry hit map, mod-16 code wrap).
  localparam int unsigned CODE_W = 4;

  // Width of the per-code dwell counter (DWELL is limited to 1..15).
  localparam int unsigned DWELL_W = 4;

  // Membership set of the Kevin numbers among 4-bit codes:
  // bit k set means code k is a match (codes 1,5,6,7,9,10,12,14).
  localparam logic [15:0] KEVIN_SET = 16'h56E2;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/kevin_match.sv
// Combinational Kevin-number detector for a single 4-bit code.
module kevin_match
  import kevin_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic              o_match
);

  // Explicit decode of the matching codes.
  always_comb begin
    o_match = 1'b0;
    unique case (i_code)
      4'd1, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd12, 4'd14: o_match = 1'b1;
      default:                                           o_match = 1'b0;
    endcase
  end

endmodule

// File: rtl/kevin_scan_ctrl.sv
// Scan controller: sweeps codes lo..hi (mod 16) through the Kevin detector,
// holding each code for DWELL cycles, and accumulates per-run results.
module kevin_scan_ctrl
  import kevin_pkg::*;
#(
  parameter int unsigned DWELL = 1  // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CODE_W-1:0] lo,
  input  logic [CODE_W-1:0] hi,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] code,
  output logic [4:0]        hit_cnt,
  output logic [15:0]       hit_map,
  output logic [CODE_W-1:0] first_hit,
  output logic              first_valid,
  output logic              aborted
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [DWELL_W-1:0]  r_dwell;
  logic [CODE_W-1:0]   r_code;
  logic [CODE_W-1:0]   r_hi;
  logic [4:0]          r_hit_cnt;
  logic [15:0]         r_hit_map;
  logic [CODE_W-1:0]   r_first_hit;
  logic                r_first_valid;
  logic                r_aborted;

  logic                w_match;
  logic                w_last_dwell;
  logic                w_capture;
  logic                w_abort;
  logic                w_eval;

  kevin_match u_match (
    .i_code  (r_code),
    .o_match (w_match)
  );

  assign w_last_dwell = (r_dwell == DWELL_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode, datapath strobes and status outputs.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_abort      = 1'b0;
    w_eval       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_capture    = 1'b1;
          w_next_state = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        // Abort wins over the evaluation scheduled for the same cycle.
        if (abort) begin
          w_abort      = 1'b1;
          w_next_state = IDLE;
        end else if (w_last_dwell) begin
          w_eval = 1'b1;
          if (r_code == r_hi) w_next_state = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Range capture, dwell counting, code advance and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwell       <= '0;
      r_code        <= '0;
      r_hi          <= '0;
      r_hit_cnt     <= '0;
      r_hit_map     <= '0;
      r_first_hit   <= '0;
      r_first_valid <= 1'b0;
      r_aborted     <= 1'b0;
    end else if (w_capture) begin
      r_dwell       <= '0;
      r_code        <= lo;
      r_hi          <= hi;
      r_hit_cnt     <= '0;
      r_hit_map     <= '0;
      r_first_hit   <= '0;
      r_first_valid <= 1'b0;
      r_aborted     <= 1'b0;
    end else if (w_abort) begin
      r_dwell   <= '0;
      r_aborted <= 1'b1;
    end else if (w_eval) begin
      r_dwell <= '0;
      if (w_match) begin
        r_hit_cnt         <= r_hit_cnt + 5'd1;
        r_hit_map[r_code] <= 1'b1;
        if (!r_first_valid) begin
          r_first_hit   <= r_code;
          r_first_valid <= 1'b1;
        end
      end
      // The final code is left on the bus through DONE and IDLE.
      if (r_code != r_hi) r_code <= r_code + 4'd1;
    end else if (r_state == SCAN) begin
      r_dwell <= r_dwell + 4'd1;
    end
  end

  assign code        = r_code;
  assign hit_cnt     = r_hit_cnt;
  assign hit_map     = r_hit_map;
  assign first_hit   = r_first_hit;
  assign first_valid = r_first_valid;
  assign aborted     = r_aborted;

endmodule

// File: tb/tb_kevin_scan_ctrl.sv
// Bench for kevin_scan_ctrl: two instances (DWELL=1 and DWELL=3) share one
// stimulus stream and are compared each cycle against a scan-progress model.
module tb_kevin_scan_ctrl;
  import kevin_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [3:0] lo = '0;
  logic [3:0] hi = '0;

  logic        busy[2], done[2], first_valid[2], aborted[2];
  logic [3:0]  code[2], first_hit[2];
  logic [4:0]  hit_cnt[2];
  logic [15:0] hit_map[2];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  kevin_scan_ctrl #(.DWELL(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .lo(lo), .hi(hi),
    .busy(busy[0]), .done(done[0]), .code(code[0]), .hit_cnt(hit_cnt[0]),
    .hit_map(hit_map[0]), .first_hit(first_hit[0]),
    .first_valid(first_valid[0]), .aborted(aborted[0])
  );

  kevin_scan_ctrl #(.DWELL(3)) u_d3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .lo(lo), .hi(hi),
    .busy(busy[1]), .done(done[1]), .code(code[1]), .hit_cnt(hit_cnt[1]),
    .hit_map(hit_map[1]), .first_hit(first_hit[1]),
    .first_valid(first_valid[1]), .aborted(aborted[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d got=%h exp=%h at %0t", name, d, got, exp, $time);
    end
  endtask

  // Model: a run is described by its start code, length, and how many
  // SCAN cycles have elapsed; results follow from how many codes were
  // fully dwelt on.
  int unsigned m_dw[2] = '{1, 3};
  bit          m_run[2]  = '{0, 0};
  bit          m_done[2] = '{0, 0};
  bit          m_ab[2]   = '{0, 0};
  int unsigned m_t[2]    = '{0, 0};
  int unsigned m_n[2]    = '{0, 0};
  int unsigned m_ev[2]   = '{0, 0};
  logic [3:0]  m_lo[2]   = '{4'd0, 4'd0};
  logic [3:0]  m_code[2] = '{4'd0, 4'd0};

  function automatic void stats(input logic [3:0] l, input int unsigned ev,
                                output logic [4:0] cnt, output logic [15:0] map,
                                output logic [3:0] fh, output logic fv);
    logic [15:0] ks;
    logic [3:0]  c;
    ks  = KEVIN_SET;
    cnt = '0; map = '0; fh = '0; fv = 1'b0;
    for (int unsigned k = 0; k < ev; k++) begin
      c = 4'((32'(l) + k) % 16);
      if (ks[c]) begin
        cnt    = cnt + 5'd1;
        map[c] = 1'b1;
        if (!fv) begin fh = c; fv = 1'b1; end
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_run[i] = 0; m_done[i] = 0; m_ab[i] = 0;
        m_t[i] = 0; m_ev[i] = 0; m_lo[i] = '0; m_code[i] = '0;
      end else if (m_done[i]) begin
        m_done[i] = 0;
      end else if (!m_run[i]) begin
        if (start) begin
          m_run[i] = 1; m_ab[i] = 0; m_t[i] = 0; m_ev[i] = 0;
          m_lo[i] = lo; m_code[i] = lo;
          m_n[i] = ((32'(hi) - 32'(lo)) & 32'hF) + 1;
        end
      end else if (abort) begin
        m_run[i] = 0; m_ab[i] = 1;
      end else begin
        m_t[i]++;
        m_ev[i] = m_t[i] / m_dw[i];
        if (m_t[i] == m_n[i] * m_dw[i]) begin
          m_run[i] = 0; m_done[i] = 1;
        end else begin
          m_code[i] = 4'((32'(m_lo[i]) + m_ev[i]) % 16);
        end
      end
    end
  end

  logic [4:0]  e_cnt;
  logic [15:0] e_map;
  logic [3:0]  e_fh;
  logic        e_fv;

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        stats(m_lo[i], m_ev[i], e_cnt, e_map, e_fh, e_fv);
        chk("busy",        i, busy[i],        m_run[i]);
        chk("done",        i, done[i],        m_done[i]);
        chk("code",        i, code[i],        m_code[i]);
        chk("hit_cnt",     i, hit_cnt[i],     e_cnt);
        chk("hit_map",     i, hit_map[i],     e_map);
        chk("first_hit",   i, first_hit[i],   e_fh);
        chk("first_valid", i, first_valid[i], e_fv);
        chk("aborted",     i, aborted[i],     m_ab[i]);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge of SCAN cycle 1.
  task automatic start_pulse(input logic [3:0] l, input logic [3:0] h,
                             input logic ab);
    lo = l; hi = h; start = 1'b1; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, busy[i], 0);
      chk("rst_code", i, code[i], 0);
      chk("rst_map",  i, hit_map[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Full scan 0..15.
    start_pulse(4'd0, 4'd15, 1'b0);
    repeat (15) @(negedge clk);
    chk("full_busy16", 0, busy[0], 1);
    chk("full_done16", 0, done[0], 0);
    @(negedge clk);
    chk("full_done17", 0, done[0], 1);
    chk("full_cnt",    0, hit_cnt[0], 8);
    chk("full_map",    0, hit_map[0], 32'h56E2);
    chk("full_fh",     0, first_hit[0], 1);
    chk("full_fv",     0, first_valid[0], 1);
    @(negedge clk);
    chk("full_idle",   0, busy[0], 0);
    repeat (40) @(negedge clk);
    chk("full_cnt",    1, hit_cnt[1], 8);
    chk("full_map",    1, hit_map[1], 32'h56E2);

    // Wrap 14,15,0,1.
    start_pulse(4'd14, 4'd1, 1'b0);
    repeat (15) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("wrap_cnt", i, hit_cnt[i], 2);
      chk("wrap_map", i, hit_map[i], 32'h4002);
      chk("wrap_fh",  i, first_hit[i], 14);
    end

    // Single code with abort also high in IDLE: start wins.
    start_pulse(4'd8, 4'd8, 1'b1);
    chk("one_busy", 0, busy[0], 1);
    @(negedge clk);
    chk("one_done", 0, done[0], 1);
    chk("one_cnt",  0, hit_cnt[0], 0);
    chk("one_map",  0, hit_map[0], 0);
    chk("one_fv",   0, first_valid[0], 0);
    chk("one_ab",   0, aborted[0], 0);
    repeat (5) @(negedge clk);

    // Dwell of 3 on codes 5,6.
    start_pulse(4'd5, 4'd6, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      chk("dw3_code", 1, code[1], (k <= 3) ? 5 : 6);
      chk("dw3_busy", 1, busy[1], 1);
      @(negedge clk);
    end
    chk("dw3_done", 1, done[1], 1);
    chk("dw3_cnt",  1, hit_cnt[1], 2);
    chk("dw3_map",  1, hit_map[1], 32'h0060);
    repeat (3) @(negedge clk);

    // Abort during the 4th SCAN cycle (code 3 on the DWELL=1 instance).
    start_pulse(4'd0, 4'd15, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", 0, busy[0], 0);
    chk("ab_flag", 0, aborted[0], 1);
    chk("ab_cnt",  0, hit_cnt[0], 1);
    chk("ab_map",  0, hit_map[0], 32'h0002);
    chk("ab_code", 0, code[0], 3);
    chk("ab_cnt",  1, hit_cnt[1], 0);
    repeat (3) @(negedge clk);

    // start held through SCAN, then reset mid-scan.
    lo = 4'd2; hi = 4'd9; start = 1'b1;
    repeat (6) @(negedge clk);
    chk("hold_code", 0, code[0], 7);
    chk("hold_busy", 0, busy[0], 1);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("mrst_busy", i, busy[i], 0);
      chk("mrst_code", i, code[i], 0);
      chk("mrst_cnt",  i, hit_cnt[i], 0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
